// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Holds the 640x480@60 defaults, the rgb444_t colour type and the
// colour-bar table used when the build defines VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Width of one test bar, in pixels.
  localparam int BAR_WIDTH = 80;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb444_t;

  // Bar colours as {B,G,R}; entry 0 is the leftmost bar (entry 0 sits at the LSB end).
  localparam logic [7:0][11:0] BAR_TABLE = {
    12'h000, 12'h00f, 12'hf00, 12'hf0f,
    12'h0f0, 12'h0ff, 12'hff0, 12'hfff
  };

  // Which bar a given column falls into; columns past the last bar reuse it.
  function automatic logic [2:0] bar_index(input logic [9:0] col);
    logic [9:0] q;
    q = col / 10'(BAR_WIDTH);
    if (q > 10'd7) begin
      return 3'd7;
    end
    return q[2:0];
  endfunction

  function automatic rgb444_t bar_color(input logic [2:0] idx);
    return rgb444_t'(BAR_TABLE[idx]);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a given value.
// DEPTH=0 collapses to a plain wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             vga_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
      // Clock and reset have no job in the zero-latency build.
      logic unused_ctrl;
      assign unused_ctrl = vga_clk ^ vga_rst;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_reg [DEPTH];

      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_next;
        if (gi == 0) begin : g_head
          assign stage_next = din;
        end else begin : g_tail
          assign stage_next = stage_reg[gi-1];
        end

        // One pipeline stage; reset flushes it to the idle value.
        always_ff @(posedge vga_clk) begin
          if (vga_rst) begin
            stage_reg[gi] <= RST_VAL;
          end else begin
            stage_reg[gi] <= stage_next;
          end
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator. Counts pixels/lines, presents the current
// coordinate to the renderer, and delays hs/vs/de by the renderer latency
// so sync, blanking and colour line up at the connector.
// Optional build macro: VGA_TEST_PATTERN_EN (test_mode selects colour bars).
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_LAT  = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [11:0] pixel_data,
  input  logic        test_mode,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_L        = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST_L = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST_L  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST_L       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_L        = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_FIRST_L = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST_L  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST_L       = 10'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_size
      $error("vga_timing_ctrl: line or frame total does not fit the 10-bit counters");
    end
    if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
      $error("vga_timing_ctrl: PIX_LAT must be in 0..4");
    end
  endgenerate

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic       act;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] tim_dly;
  rgb444_t    pix_sel;

  // Next counter values: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST_L) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST_L) ? '0 : v_cnt_reg + 10'd1;
    end
  end

  // Counter registers; reset restarts the frame at (0,0).
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Undelayed timing decode; sync asserts at SYNC_POL inside its window.
  always_comb begin
    act    = (h_cnt_reg < H_ACT_L) && (v_cnt_reg < V_ACT_L);
    hs_raw = ((h_cnt_reg >= H_SYNC_FIRST_L) && (h_cnt_reg <= H_SYNC_LAST_L)) ? SYNC_POL : ~SYNC_POL;
    vs_raw = ((v_cnt_reg >= V_SYNC_FIRST_L) && (v_cnt_reg <= V_SYNC_LAST_L)) ? SYNC_POL : ~SYNC_POL;
  end

  // Coordinates go to the renderer undelayed; it supplies the latency.
  assign x_pos       = act ? h_cnt_reg : '0;
  assign y_pos       = act ? v_cnt_reg : '0;
  assign frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_tim_dly (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .din     ({hs_raw, vs_raw, act}),
    .dout    (tim_dly)
  );

  assign hs = tim_dly[2];
  assign vs = tim_dly[1];
  assign de = tim_dly[0];

`ifdef VGA_TEST_PATTERN_EN
  // Column delayed alongside de so the bars line up with the blanking.
  logic [9:0] col_dly;

  vga_delay_line #(
    .WIDTH   (10),
    .DEPTH   (PIX_LAT),
    .RST_VAL ('0)
  ) u_col_dly (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .din     (x_pos),
    .dout    (col_dly)
  );
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Colour select and blanking; pixel_data arrives in step with delayed de.
  always_comb begin
    pix_sel = rgb444_t'(pixel_data);
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      pix_sel = bar_color(bar_index(col_dly));
    end
`endif
    if (!de) begin
      pix_sel = '0;
    end
  end

  assign vga_b = pix_sel.b;
  assign vga_g = pix_sel.g;
  assign vga_r = pix_sel.r;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default 640x480 instance and a
// shrunken instance (25x10 raster, PIX_LAT=2) for whole-frame behaviour.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_s = 1'b1;
  logic [11:0] pixel_data = 12'h000;
  logic [11:0] pd_s = 12'h3c5;
  logic        test_mode = 1'b0;
  logic        test_mode_s = 1'b0;

  logic [9:0] x_pos, y_pos, x_pos_s, y_pos_s;
  logic       hs, vs, de, frame_start, hs_s, vs_s, de_s, frame_start_s;
  logic [3:0] vga_r, vga_g, vga_b, vga_r_s, vga_g_s, vga_b_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .vga_clk(clk), .vga_rst(rst), .pixel_data(pixel_data), .test_mode(test_mode),
    .x_pos(x_pos), .y_pos(y_pos), .hs(hs), .vs(vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .de(de), .frame_start(frame_start)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIX_LAT(2)
  ) dut_s (
    .vga_clk(clk), .vga_rst(rst_s), .pixel_data(pd_s), .test_mode(test_mode_s),
    .x_pos(x_pos_s), .y_pos(y_pos_s), .hs(hs_s), .vs(vs_s),
    .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s), .de(de_s), .frame_start(frame_start_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pixel_data = 12'h0f0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({x_pos, y_pos} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_pos: x=%0d y=%0d, expected 0 0", x_pos, y_pos);
    end
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_frame_start: got %b expected 1", frame_start);
    end
    n_checks++;
    if ({de, hs, vs} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_de_hs_vs: got %b expected 011", {de, hs, vs});
    end
    n_checks++;
    if ({vga_b, vga_g, vga_r} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_colour: got %h expected 000", {vga_b, vga_g, vga_r});
    end
    step();
    n_checks++;
    if ({de, frame_start, vga_g} !== 6'b10_1111) begin
      n_fail++;
      $display("FAIL first_pixel: de=%b fs=%b g=%h expected de=1 fs=0 g=f", de, frame_start, vga_g);
    end
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Cycles 1..1500 after release; first line holds 0f0, second line varies colour.
  task automatic test_line();
    int h, v, hp, vp, hs_low, hs_first;
    logic e_act, e_de, e_hs, e_vs, e_fs;
    logic [11:0] e_col;
    logic [35:0] exp_vec, got_vec;
    hs_low = 0;
    hs_first = -1;
    for (int k = 1; k <= 1500; k++) begin
      pixel_data = (k < 800) ? 12'h0f0 : (12'(k * 37) ^ 12'h5a3);
      #1;
      h = k % 800; v = (k / 800) % 525;
      hp = (k - 1) % 800; vp = ((k - 1) / 800) % 525;
      e_act = (h < 640) && (v < 480);
      e_de  = (hp < 640) && (vp < 480);
      e_hs  = !(hp >= 656 && hp <= 751);
      e_vs  = !(vp >= 490 && vp <= 491);
      e_fs  = (h == 0) && (v == 0);
      e_col = e_de ? pixel_data : 12'h000;
      exp_vec = {(e_act ? 10'(h) : 10'd0), (e_act ? 10'(v) : 10'd0), e_hs, e_vs, e_de, e_fs, e_col};
      got_vec = {x_pos, y_pos, hs, vs, de, frame_start, vga_b, vga_g, vga_r};
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL line_cycle_%0d: {x,y,hs,vs,de,fs,bgr} got %h expected %h", k, got_vec, exp_vec);
      end
      if (k < 800 && hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k < 1500) step();
    end
    n_checks++;
    if (hs_low != 96) begin
      n_fail++;
      $display("FAIL hs_width: got %0d cycles low, expected 96", hs_low);
    end
    n_checks++;
    if (hs_first != 657) begin
      n_fail++;
      $display("FAIL hs_start: got cycle %0d, expected 657", hs_first);
    end
    $display("test_line done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Called at cycle 1500 (h=700, inside hsync): one reset cycle restarts at (0,0).
  task automatic test_mid_reset_main();
    pixel_data = 12'hfff;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({x_pos, y_pos, hs, vs, de, frame_start, vga_b, vga_g, vga_r} !== {20'd0, 4'b1101, 12'h000}) begin
      n_fail++;
      $display("FAIL mid_reset_main: x=%0d y=%0d hs=%b vs=%b de=%b fs=%b bgr=%h expected 0 0 1 1 0 1 000",
               x_pos, y_pos, hs, vs, de, frame_start, {vga_b, vga_g, vga_r});
    end
    $display("test_mid_reset_main done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Small raster: H 16/2/4/3 (25), V 6/1/2/1 (10), frame = 250 cycles, PIX_LAT=2.
  task automatic test_frame_small();
    int h, v, hp, vp, vs_low, vs_first, fs_cnt;
    logic e_act, e_de, e_hs, e_vs, e_fs;
    logic [11:0] e_col;
    logic [35:0] exp_vec, got_vec;
    vs_low = 0; vs_first = -1; fs_cnt = 0;
    rst_s = 1'b0;
    #1;
    for (int k = 0; k <= 721; k++) begin
      h = k % 25; v = (k / 25) % 10;
      e_act = (h < 16) && (v < 6);
      if (k >= 2) begin
        hp = (k - 2) % 25; vp = ((k - 2) / 25) % 10;
        e_de = (hp < 16) && (vp < 6);
        e_hs = !(hp >= 18 && hp <= 21);
        e_vs = !(vp >= 7 && vp <= 8);
      end else begin
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end
      e_fs  = (h == 0) && (v == 0);
      e_col = e_de ? pd_s : 12'h000;
      exp_vec = {(e_act ? 10'(h) : 10'd0), (e_act ? 10'(v) : 10'd0), e_hs, e_vs, e_de, e_fs, e_col};
      got_vec = {x_pos_s, y_pos_s, hs_s, vs_s, de_s, frame_start_s, vga_b_s, vga_g_s, vga_r_s};
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL small_cycle_%0d: {x,y,hs,vs,de,fs,bgr} got %h expected %h", k, got_vec, exp_vec);
      end
      if (k < 250 && vs_s === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (frame_start_s === 1'b1) fs_cnt++;
      if (k < 721) step();
    end
    n_checks++;
    if (vs_low != 50) begin
      n_fail++;
      $display("FAIL small_vs_width: got %0d cycles low, expected 50", vs_low);
    end
    n_checks++;
    if (vs_first != 177) begin
      n_fail++;
      $display("FAIL small_vs_start: got cycle %0d, expected 177", vs_first);
    end
    n_checks++;
    if (fs_cnt != 3) begin
      n_fail++;
      $display("FAIL small_frame_start_count: got %0d pulses in 722 cycles, expected 3", fs_cnt);
    end
    $display("test_frame_small done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Cycle 721 of the small raster is h=21, v=8 with hs and vs both low.
  task automatic test_mid_reset_small();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    #1;
    n_checks++;
    if ({x_pos_s, y_pos_s, hs_s, vs_s, de_s, frame_start_s, vga_b_s, vga_g_s, vga_r_s} !== {20'd0, 4'b1101, 12'h000}) begin
      n_fail++;
      $display("FAIL mid_reset_small: x=%0d y=%0d hs=%b vs=%b de=%b fs=%b bgr=%h expected 0 0 1 1 0 1 000",
               x_pos_s, y_pos_s, hs_s, vs_s, de_s, frame_start_s, {vga_b_s, vga_g_s, vga_r_s});
    end
    step();
    n_checks++;
    if ({hs_s, vs_s, de_s} !== 3'b110) begin
      n_fail++;
      $display("FAIL flush_stage2: hs,vs,de got %b expected 110", {hs_s, vs_s, de_s});
    end
    step();
    n_checks++;
    if ({de_s, vga_b_s, vga_g_s, vga_r_s} !== {1'b1, pd_s}) begin
      n_fail++;
      $display("FAIL de_after_lat2: de,bgr got %h expected %h", {de_s, vga_b_s, vga_g_s, vga_r_s}, {1'b1, pd_s});
    end
    $display("test_mid_reset_small done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Colour bars keyed on the delayed column; pixel_data passes through without the macro.
  task automatic test_pattern();
    logic [11:0] e_col;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    test_mode = 1'b1;
    pixel_data = 12'h123;
    #1;
    for (int k = 1; k <= 641; k++) begin
      step();
      if (k == 1 || k == 80 || k == 81 || k == 86 || k == 161 || k == 640 || k == 641) begin
`ifdef VGA_TEST_PATTERN_EN
        case (k)
          1, 80:   e_col = 12'hfff;
          81, 86:  e_col = 12'hff0;
          161:     e_col = 12'h0ff;
          default: e_col = 12'h000;
        endcase
`else
        e_col = (k == 641) ? 12'h000 : 12'h123;
`endif
        n_checks++;
        if ({vga_b, vga_g, vga_r} !== e_col) begin
          n_fail++;
          $display("FAIL pattern_col_%0d: bgr got %h expected %h", k - 1, {vga_b, vga_g, vga_r}, e_col);
        end
      end
    end
    test_mode = 1'b0;
    $display("test_pattern done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    test_reset();
    test_line();
    test_mid_reset_main();
    test_frame_small();
    test_mid_reset_small();
    test_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
